hmmm_pgrm_loader: RTL

//  Host-side transmitter for the Hmmm core's two-wire serial program-load port.

---
 rtl/hmmm_pgrm_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hmmm_pgrm_loader.sv
// Host-side serializer for the Hmmm core program-load port.
// Takes (address, instruction) words on valid/ready and emits START / MSB-first bits / STOP frames.
module hmmm_pgrm_loader #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              pgrm_addr,
    output logic              pgrm_data,
    output logic              busy,
    output logic              done,
    output logic [8:0]        words_sent
);

    localparam int unsigned TMR_W = 8;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned CNT_W = 9;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t             r_state,     w_state_d;
    logic [TMR_W-1:0]   r_timer,     w_timer_d;
    logic [IDX_W-1:0]   r_idx,       w_idx_d;
    logic [DATA_W-1:0]  r_sh_data,   w_sh_data_d;
    logic [DATA_W-1:0]  r_sh_addr,   w_sh_addr_d;
    logic               r_last,      w_last_d;
    logic               r_restart,   w_restart_d;
    logic [CNT_W-1:0]   r_words,     w_words_d;
    logic               r_done,      w_done_d;
    logic               r_pgrm_addr, w_pgrm_addr_d;
    logic               r_pgrm_data, w_pgrm_data_d;
    logic               r_busy;
    logic               w_accept;
    logic [DATA_W-1:0]  w_addr_ext;

    assign s_ready    = (r_state == ST_IDLE) && rst_n;
    assign w_accept   = s_valid && s_ready;
    // Address is left-aligned so both lines shift out of the same MSB position.
    assign w_addr_ext = DATA_W'(s_addr) << (DATA_W - ADDR_W);

    // Next-state, datapath and next line values.
    always_comb begin
        w_state_d   = r_state;
        w_timer_d   = r_timer;
        w_idx_d     = r_idx;
        w_sh_data_d = r_sh_data;
        w_sh_addr_d = r_sh_addr;
        w_last_d    = r_last;
        w_restart_d = r_restart;
        w_words_d   = r_words;
        w_done_d    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d   = ST_START;
                    w_timer_d   = TMR_RELOAD;
                    w_sh_data_d = s_data;
                    w_sh_addr_d = w_addr_ext;
                    w_last_d    = s_last;
                    if (r_restart) begin
                        w_words_d   = '0;
                        w_restart_d = 1'b0;
                    end
                end
            end
            ST_START: begin
                if (r_timer == '0) begin
                    w_state_d = ST_SHIFT;
                    w_timer_d = TMR_RELOAD;
                    w_idx_d   = '0;
                end else begin
                    w_timer_d = r_timer - TMR_W'(1);
                end
            end
            ST_SHIFT: begin
                if (r_timer == '0) begin
                    w_timer_d = TMR_RELOAD;
                    if (r_idx == IDX_LAST) begin
                        w_state_d = ST_STOP;
                    end else begin
                        w_idx_d     = r_idx + IDX_W'(1);
                        w_sh_data_d = r_sh_data << 1;
                        w_sh_addr_d = r_sh_addr << 1;
                    end
                end else begin
                    w_timer_d = r_timer - TMR_W'(1);
                end
            end
            ST_STOP: begin
                if (r_timer == '0) begin
                    w_state_d = ST_IDLE;
                    if (r_words != CNT_MAX) begin
                        w_words_d = r_words + CNT_W'(1);
                    end
                    if (r_last) begin
                        w_done_d    = 1'b1;
                        w_restart_d = 1'b1;
                    end
                end else begin
                    w_timer_d = r_timer - TMR_W'(1);
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        w_pgrm_data_d = (w_state_d == ST_START) ||
                        ((w_state_d == ST_SHIFT) && w_sh_data_d[DATA_W-1]);
        w_pgrm_addr_d = (w_state_d == ST_START) ||
                        ((w_state_d == ST_SHIFT) && w_sh_addr_d[DATA_W-1]);
    end

    // State and output registers; lines only move on slot boundaries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_idx       <= '0;
            r_sh_data   <= '0;
            r_sh_addr   <= '0;
            r_last      <= 1'b0;
            r_restart   <= 1'b0;
            r_words     <= '0;
            r_done      <= 1'b0;
            r_pgrm_addr <= 1'b0;
            r_pgrm_data <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_timer     <= w_timer_d;
            r_idx       <= w_idx_d;
            r_sh_data   <= w_sh_data_d;
            r_sh_addr   <= w_sh_addr_d;
            r_last      <= w_last_d;
            r_restart   <= w_restart_d;
            r_words     <= w_words_d;
            r_done      <= w_done_d;
            r_pgrm_addr <= w_pgrm_addr_d;
            r_pgrm_data <= w_pgrm_data_d;
            r_busy      <= (w_state_d != ST_IDLE);
        end
    end

    assign pgrm_addr  = r_pgrm_addr;
    assign pgrm_data  = r_pgrm_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign words_sent = r_words;

endmodule
